// File: rtl/gen_count_ctrl.sv
// gen_count_ctrl
//   Control stage in front of the generation-count 7-segment display.
//   Debounces the run / step / clear buttons, issues one-cycle generation
//   requests to the grid engine (automatically every TICK_DIV cycles while
//   running, or one per step press while paused), and counts the completed
//   generations, saturating at MAX_COUNT.
//
// Ports
//   clock      : system clock
//   reset      : synchronous, active-high reset
//   btn_run    : raw button, each press toggles run/pause
//   btn_step   : raw button, each press requests one generation while paused
//   btn_clear  : raw button, each press zeroes the count
//   gen_done   : one-cycle completion pulse from the grid engine
//   gen_start  : one-cycle request pulse to the grid engine
//   num        : completed-generation count, 0..MAX_COUNT
//   running    : 1 = auto-run mode
//   busy       : 1 = request outstanding
module gen_count_ctrl #(
    parameter int TICK_DIV  = 25000000,
    parameter int DEBOUNCE  = 65536,
    parameter int MAX_COUNT = 9999
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_run,
    input  logic        btn_step,
    input  logic        btn_clear,
    input  logic        gen_done,
    output logic        gen_start,
    output logic [13:0] num,
    output logic        running,
    output logic        busy
);

    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int TK_W = $clog2(TICK_DIV);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);
    localparam logic [13:0]     NUM_MAX = 14'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Saturating increment of the generation count.
    function automatic logic [13:0] sat_inc(input logic [13:0] v);
        return (v >= NUM_MAX) ? NUM_MAX : v + 14'd1;
    endfunction

    // Button bit order: [0] run, [1] step, [2] clear.
    logic [2:0]      btn_raw;
    logic [2:0]      btn_sync1;
    logic [2:0]      btn_sync2;
    logic [2:0]      btn_level;
    logic [2:0]      btn_level_d;
    logic [2:0]      btn_press;
    logic [DB_W-1:0] db_cnt [3];

    logic            run_press;
    logic            step_press;
    logic            clear_press;

    state_t          state;
    state_t          state_nxt;
    logic [TK_W-1:0] tick;
    logic            tick_wrap;

    assign btn_raw = {btn_clear, btn_step, btn_run};

    // ---- stage: synchronise, debounce, edge-detect ----
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_sync1   <= '0;
            btn_sync2   <= '0;
            btn_level   <= '0;
            btn_level_d <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            btn_sync1   <= btn_raw;
            btn_sync2   <= btn_sync1;
            btn_level_d <= btn_level;
            for (int i = 0; i < 3; i++) begin
                // Any sample that agrees with the accepted level restarts the
                // count, so only DEBOUNCE consecutive disagreeing samples flip it.
                if (btn_sync2[i] == btn_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i]    <= '0;
                    btn_level[i] <= btn_sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign btn_press   = btn_level & ~btn_level_d;
    assign run_press   = btn_press[0];
    assign step_press  = btn_press[1];
    assign clear_press = btn_press[2];

    assign tick_wrap = (tick == TK_LAST);

    // ---- stage: request FSM next state ----
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (running && tick_wrap) begin
                    state_nxt = REQ;
                end else if (!running && step_press) begin
                    state_nxt = REQ;
                end
            end
            REQ:  state_nxt = WAIT;
            WAIT: begin
                if (gen_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- stage: state, tick counter, count and registered outputs ----
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            tick      <= '0;
            running   <= 1'b0;
            gen_start <= 1'b0;
            busy      <= 1'b0;
            num       <= '0;
        end else begin
            state     <= state_nxt;
            // Outputs decode the next state so they line up with the state
            // register instead of lagging it by a cycle.
            gen_start <= (state_nxt == REQ);
            busy      <= (state_nxt != IDLE);

            if (run_press) begin
                running <= ~running;
            end

            // The tick only advances while idling in run mode; the wrap edge
            // is the same edge on which the FSM enters REQ.
            if (clear_press || !running || state != IDLE || tick_wrap) begin
                tick <= '0;
            end else begin
                tick <= tick + TK_W'(1);
            end

            // Clear takes priority over a coincident completion.
            if (clear_press) begin
                num <= '0;
            end else if (state == WAIT && gen_done) begin
                num <= sat_inc(num);
            end
        end
    end

endmodule
